// File: rtl/sad_min_select_if.sv
// Bundles the SAD candidate inputs and the best-match results.
// The master modport is the candidate source and the slave modport is the selector.
interface sad_min_select_if #(
  parameter int MVW = 6
);
  logic                 start;
  logic                 sad_valid;
  logic [17:0]          sad32;
  logic [63:0]          sad16;
  logic [223:0]         sad8;
  logic                 busy;
  logic                 done;
  logic [17:0]          best32_sad;
  logic [2*MVW-1:0]     best32_mv;
  logic [63:0]          best16_sad;
  logic [8*MVW-1:0]     best16_mv;
  logic [223:0]         best8_sad;
  logic [32*MVW-1:0]    best8_mv;

  modport master (
    output start, sad_valid, sad32, sad16, sad8,
    input  busy, done, best32_sad, best32_mv, best16_sad, best16_mv,
           best8_sad, best8_mv
  );

  modport slave (
    input  start, sad_valid, sad32, sad16, sad8,
    output busy, done, best32_sad, best32_mv, best16_sad, best16_mv,
           best8_sad, best8_mv
  );
endinterface

// File: rtl/sad_min_select.sv
// Tracks the minimum SAD and its motion vector for each 32/16/8 partition
// over a raster search of (2*SR)^2 candidates.
//   state  | meaning
//   IDLE   | waiting for start; best registers hold the last result
//   SEARCH | accepting candidates while sad_valid is high
//   DONE   | one-cycle done pulse; results are final
module sad_min_select #(
  parameter int SR  = 16,
  parameter int MVW = 6
) (
  input logic          clk,
  input logic          rst_n,
  sad_min_select_if.slave bus
);
  localparam int N  = (2 * SR) * (2 * SR);
  localparam int CW = $clog2(N);
  localparam int MW = 2 * MVW;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [17:0]         b32_sad;
  logic [MW-1:0]       b32_mv;
  logic [63:0]         b16_sad;
  logic [4*MW-1:0]     b16_mv;
  logic [223:0]        b8_sad;
  logic [16*MW-1:0]    b8_mv;

  logic                accept;
  logic                first;
  logic [MVW-1:0]      mv_x;
  logic [MVW-1:0]      mv_y;
  logic [MW-1:0]       mv;

  always_comb begin
    accept = (state == SEARCH) && bus.sad_valid;
    first  = (cnt == '0);
    mv_x   = MVW'(int'(cnt) % (2 * SR) - SR);
    mv_y   = MVW'(int'(cnt) / (2 * SR) - SR);
    mv     = {mv_y, mv_x};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      b32_sad <= '0;
      b32_mv  <= '0;
      b16_sad <= '0;
      b16_mv  <= '0;
      b8_sad  <= '0;
      b8_mv   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt   <= '0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Strict less-than keeps the earliest candidate on ties.
      if (accept) begin
        if (first || bus.sad32 < b32_sad) begin
          b32_sad <= bus.sad32;
          b32_mv  <= mv;
        end
        for (int k = 0; k < 4; k++) begin
          if (first || bus.sad16[16*k +: 16] < b16_sad[16*k +: 16]) begin
            b16_sad[16*k +: 16] <= bus.sad16[16*k +: 16];
            b16_mv[MW*k +: MW]  <= mv;
          end
        end
        for (int k = 0; k < 16; k++) begin
          if (first || bus.sad8[14*k +: 14] < b8_sad[14*k +: 14]) begin
            b8_sad[14*k +: 14] <= bus.sad8[14*k +: 14];
            b8_mv[MW*k +: MW]  <= mv;
          end
        end
      end
    end
  end

  assign bus.busy       = (state == SEARCH);
  assign bus.done       = (state == DONE);
  assign bus.best32_sad = b32_sad;
  assign bus.best32_mv  = b32_mv;
  assign bus.best16_sad = b16_sad;
  assign bus.best16_mv  = b16_mv;
  assign bus.best8_sad  = b8_sad;
  assign bus.best8_mv   = b8_mv;
endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select at SR=2: a queue-based model of accepted
// candidates is checked every cycle, plus hand-computed literal results.
module tb_sad_min_select;
  localparam int SR  = 2;
  localparam int MVW = 6;
  localparam int N   = 16;
  localparam int MW  = 2 * MVW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sad_min_select_if #(.MVW(MVW)) bus ();
  sad_min_select #(.SR(SR), .MVW(MVW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Model: candidates accepted in the current search, plus the held result.
  logic [17:0]       q32[$];
  logic [63:0]       q16[$];
  logic [223:0]      q8[$];
  int                phase = 0;  // 0 waiting, 1 searching, 2 done cycle
  logic [17:0]       h32s = '0;
  logic [MW-1:0]     h32m = '0;
  logic [63:0]       h16s = '0;
  logic [4*MW-1:0]   h16m = '0;
  logic [223:0]      h8s = '0;
  logic [16*MW-1:0]  h8m = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mv_of(input int i);
    logic [MVW-1:0] x, y;
    x = MVW'(i % (2 * SR) - SR);
    y = MVW'(i / (2 * SR) - SR);
    return {y, x};
  endfunction

  task automatic calc(output logic [17:0] s32, output logic [MW-1:0] m32,
                      output logic [63:0] s16, output logic [4*MW-1:0] m16,
                      output logic [223:0] s8, output logic [16*MW-1:0] m8);
    s32 = q32[0]; m32 = mv_of(0);
    s16 = q16[0]; m16 = {4{mv_of(0)}};
    s8  = q8[0];  m8  = {16{mv_of(0)}};
    for (int i = 1; i < q32.size(); i++) begin
      if (q32[i] < s32) begin s32 = q32[i]; m32 = mv_of(i); end
      for (int k = 0; k < 4; k++)
        if (q16[i][16*k +: 16] < s16[16*k +: 16]) begin
          s16[16*k +: 16] = q16[i][16*k +: 16];
          m16[MW*k +: MW] = mv_of(i);
        end
      for (int k = 0; k < 16; k++)
        if (q8[i][14*k +: 14] < s8[14*k +: 14]) begin
          s8[14*k +: 14] = q8[i][14*k +: 14];
          m8[MW*k +: MW] = mv_of(i);
        end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      phase = 0;
      q32.delete(); q16.delete(); q8.delete();
      h32s = '0; h32m = '0; h16s = '0; h16m = '0; h8s = '0; h8m = '0;
    end else begin
      case (phase)
        0: if (bus.start) begin
             if (q32.size() > 0) calc(h32s, h32m, h16s, h16m, h8s, h8m);
             q32.delete(); q16.delete(); q8.delete();
             phase = 1;
           end
        1: if (bus.sad_valid) begin
             q32.push_back(bus.sad32);
             q16.push_back(bus.sad16);
             q8.push_back(bus.sad8);
             if (q32.size() == N) phase = 2;
           end
        default: phase = 0;
      endcase
    end
  end

  initial forever begin
    logic [17:0] e32s; logic [MW-1:0] e32m;
    logic [63:0] e16s; logic [4*MW-1:0] e16m;
    logic [223:0] e8s; logic [16*MW-1:0] e8m;
    @(negedge clk);
    if (q32.size() > 0) calc(e32s, e32m, e16s, e16m, e8s, e8m);
    else begin
      e32s = h32s; e32m = h32m; e16s = h16s; e16m = h16m; e8s = h8s; e8m = h8m;
    end
    chk("busy", bus.busy, phase == 1);
    chk("done", bus.done, phase == 2);
    chk("best32_sad", bus.best32_sad, e32s);
    chk("best32_mv", bus.best32_mv, e32m);
    chk("best16_sad", bus.best16_sad, e16s);
    chk("best16_mv", bus.best16_mv, e16m);
    chk("best8_sad", bus.best8_sad, e8s);
    chk("best8_mv", bus.best8_mv, e8m);
    if (bus.done) done_cnt++;
  end

  task automatic gen(input int kind, input int i);
    bus.sad32 = '0; bus.sad16 = '0; bus.sad8 = '0;
    case (kind)
      0: begin
        bus.sad32 = 18'(100 - i);
        bus.sad16 = {$urandom, $urandom};
        bus.sad8  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      1: begin
        bus.sad32 = 18'd50;
        bus.sad16 = {4{16'd50}};
        bus.sad8  = {16{14'd50}};
      end
      2: begin
        bus.sad32 = 18'd1000;
        bus.sad16 = {4{16'd1000}};
        bus.sad8  = {16{14'd1000}};
        if (i == 6) bus.sad8[5*14 +: 14] = 14'd0;
      end
      3: begin
        bus.sad32 = (i == 15) ? 18'd0 : 18'h3ffff;
        bus.sad16 = {$urandom, $urandom};
        bus.sad8  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      default: begin
        bus.sad32 = 18'($urandom_range(0, 7));
        for (int k = 0; k < 4; k++) bus.sad16[16*k +: 16] = 16'($urandom_range(0, 7));
        for (int k = 0; k < 16; k++) bus.sad8[14*k +: 14] = 14'($urandom_range(0, 7));
      end
    endcase
  endtask

  task automatic run(input int kind, input bit gaps);
    int d0;
    int i;
    d0 = done_cnt;
    bus.start = 1'b1;
    gen(kind, 99);
    bus.sad_valid = gaps;  // valid alongside start must not be taken
    @(negedge clk);
    bus.start = 1'b0;
    bus.sad_valid = 1'b0;
    i = 0;
    while (i < N) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.sad_valid = 1'b0;
        bus.start = (i == 5);
      end else begin
        gen(kind, i);
        bus.sad_valid = 1'b1;
        bus.start = gaps && (i == 9);
        i++;
      end
      @(negedge clk);
    end
    bus.sad_valid = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.sad_valid = 1'b0;
    bus.sad32 = '0; bus.sad16 = '0; bus.sad8 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_best32", bus.best32_sad, 0);
    chk("reset_busy", bus.busy, 0);

    bus.sad_valid = 1'b1;
    gen(1, 0);
    repeat (2) @(negedge clk);
    bus.sad_valid = 1'b0;
    chk("idle_valid_ignored", bus.best8_sad, 0);

    run(0, 1'b0);
    chk("ramp_sad32", bus.best32_sad, 18'd85);
    chk("ramp_mv32", bus.best32_mv, 12'h041);

    run(1, 1'b0);
    chk("tie_sad16", bus.best16_sad, {4{16'd50}});
    chk("tie_mv16", bus.best16_mv, {4{12'hfbe}});
    chk("tie_sad8", bus.best8_sad, {16{14'd50}});
    chk("tie_mv8", bus.best8_mv, {16{12'hfbe}});
    chk("tie_mv32", bus.best32_mv, 12'hfbe);

    run(2, 1'b0);
    chk("e5_sad", bus.best8_sad[5*14 +: 14], 14'd0);
    chk("e5_mv", bus.best8_mv[5*MW +: MW], 12'hfc0);
    chk("e4_sad", bus.best8_sad[4*14 +: 14], 14'd1000);
    chk("e4_mv", bus.best8_mv[4*MW +: MW], 12'hfbe);

    run(3, 1'b0);
    chk("max_sad32", bus.best32_sad, 18'd0);
    chk("max_mv32", bus.best32_mv, 12'h041);

    run(4, 1'b0);
    run(4, 1'b0);

    run(0, 1'b1);
    chk("gap_sad32", bus.best32_sad, 18'd85);
    chk("gap_mv32", bus.best32_mv, 12'h041);

    begin
      int d0;
      d0 = done_cnt;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 7; i++) begin
        gen(4, i);
        bus.sad_valid = 1'b1;
        @(negedge clk);
      end
      bus.sad_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_best32", bus.best32_sad, 0);
      chk("abort_best8", bus.best8_sad, 0);
      chk("abort_mv16", bus.best16_mv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
    end

    run(3, 1'b0);
    chk("after_abort_sad32", bus.best32_sad, 18'd0);
    chk("after_abort_mv32", bus.best32_mv, 12'h041);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
